// File: rtl/pc_stack_if.sv
// pc_stack_if: command and status bundle between a fetch sequencer and pc_stack_unit.
interface pc_stack_if #(parameter int AW = 8, parameter int DEPTH = 4);
  localparam int SW = $clog2(DEPTH + 1);
  logic          en;
  logic          inc;
  logic          jmp;
  logic          jmp_rel;
  logic [AW-1:0] jmp_add;
  logic          call;
  logic          ret;
  logic          err_clr;
  logic [AW-1:0] add;
  logic [SW-1:0] sp;
  logic          full;
  logic          empty;
  logic          ovf;
  logic          unf;
  modport master (output en, inc, jmp, jmp_rel, jmp_add, call, ret, err_clr,
                  input add, sp, full, empty, ovf, unf);
  modport slave  (input en, inc, jmp, jmp_rel, jmp_add, call, ret, err_clr,
                  output add, sp, full, empty, ovf, unf);
endinterface

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with return-address stack, stall and sticky stack-error flags.
module pc_stack_unit #(
  parameter int AW = 8,
  parameter int STEP = 4,
  parameter int DEPTH = 4,
  parameter int RESET_ADDR = 0
) (
  input logic clk,
  input logic rst,
  pc_stack_if.slave bus
);
  localparam int SW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [AW-1:0] stack [DEPTH];
  logic [AW-1:0] add_step, target, add_next;
  logic [SW-1:0] sp_dec, sp_next;
  logic do_ret, do_call, do_jmp, do_inc, pop_ok, push_ok, ovf_next, unf_next;
  assign bus.full  = bus.sp == SW'(DEPTH);
  assign bus.empty = bus.sp == '0;
  assign add_step  = bus.add + AW'(STEP);
  // same-width add is already sign-extended modulo 2**AW
  assign target    = bus.jmp_rel ? bus.add + bus.jmp_add : bus.jmp_add;
  assign sp_dec    = bus.sp - SW'(1);
  always_comb begin
    do_ret   = bus.en & bus.ret;
    do_call  = bus.en & ~bus.ret & bus.call;
    do_jmp   = bus.en & ~bus.ret & ~bus.call & bus.jmp;
    do_inc   = bus.en & ~bus.ret & ~bus.call & ~bus.jmp & bus.inc;
    pop_ok   = do_ret & ~bus.empty;
    push_ok  = do_call & ~bus.full;
    ovf_next = (do_call & bus.full) | (bus.ovf & ~bus.err_clr);
    unf_next = (do_ret & bus.empty) | (bus.unf & ~bus.err_clr);
    add_next = pop_ok ? stack[sp_dec[IW-1:0]] :
               (do_call | do_jmp) ? target :
               do_inc ? add_step : bus.add;
    sp_next  = pop_ok ? sp_dec : push_ok ? bus.sp + SW'(1) : bus.sp;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.add <= AW'(RESET_ADDR);
      bus.sp  <= '0;
      bus.ovf <= 1'b0;
      bus.unf <= 1'b0;
    end else begin
      bus.add <= add_next;
      bus.sp  <= sp_next;
      bus.ovf <= ovf_next;
      bus.unf <= unf_next;
    end
  always_ff @(posedge clk)
    if (push_ok) stack[bus.sp[IW-1:0]] <= add_step;
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: directed vector table plus hand sequences for reset, wrap and stack limits.
module tb_pc_stack_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  pc_stack_if #(.AW(8), .DEPTH(4)) bus ();
  pc_stack_unit #(.AW(8), .STEP(4), .DEPTH(4), .RESET_ADDR(0)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    bit en, inc, jmp, rel;
    logic [7:0] ja;
    bit call, ret, clr;
    logic [7:0] ea;
    logic [2:0] es;
    bit eo, eu;
  } vec_t;
  vec_t vecs [18];
  function automatic vec_t v(bit en, bit inc, bit jmp, bit rel, logic [7:0] ja, bit call, bit ret,
                             bit clr, logic [7:0] ea, logic [2:0] es, bit eo, bit eu);
    vec_t x;
    x.en = en; x.inc = inc; x.jmp = jmp; x.rel = rel; x.ja = ja; x.call = call; x.ret = ret;
    x.clr = clr; x.ea = ea; x.es = es; x.eo = eo; x.eu = eu;
    return x;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_state(string name, logic [7:0] ea, logic [2:0] es, bit eo, bit eu);
    chk({name, ".add"}, 32'(bus.add), 32'(ea));
    chk({name, ".sp"}, 32'(bus.sp), 32'(es));
    chk({name, ".full"}, 32'(bus.full), 32'(es == 3'd4));
    chk({name, ".empty"}, 32'(bus.empty), 32'(es == 3'd0));
    chk({name, ".ovf"}, 32'(bus.ovf), 32'(eo));
    chk({name, ".unf"}, 32'(bus.unf), 32'(eu));
  endtask
  task automatic drive(bit en, bit inc, bit jmp, bit rel, logic [7:0] ja, bit call, bit ret, bit clr);
    bus.en = en; bus.inc = inc; bus.jmp = jmp; bus.jmp_rel = rel; bus.jmp_add = ja;
    bus.call = call; bus.ret = ret; bus.err_clr = clr;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    drive(0, 0, 0, 0, 8'h00, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  initial begin
    vecs[0]  = v(1, 0, 1, 0, 8'h20, 0, 0, 0, 8'h20, 0, 0, 0);
    vecs[1]  = v(1, 0, 1, 0, 8'h05, 0, 0, 0, 8'h05, 0, 0, 0);
    vecs[2]  = v(1, 0, 1, 0, 8'h20, 0, 0, 0, 8'h20, 0, 0, 0);
    vecs[3]  = v(1, 0, 1, 1, 8'hFB, 0, 0, 0, 8'h1B, 0, 0, 0);
    vecs[4]  = v(1, 0, 1, 0, 8'h10, 0, 0, 0, 8'h10, 0, 0, 0);
    vecs[5]  = v(1, 0, 0, 0, 8'h80, 1, 0, 0, 8'h80, 1, 0, 0);
    vecs[6]  = v(1, 1, 0, 0, 8'h00, 0, 0, 0, 8'h84, 1, 0, 0);
    vecs[7]  = v(1, 0, 0, 0, 8'h00, 0, 1, 0, 8'h14, 0, 0, 0);
    vecs[8]  = v(1, 0, 0, 1, 8'h10, 1, 0, 0, 8'h24, 1, 0, 0);
    vecs[9]  = v(1, 1, 1, 0, 8'h40, 1, 1, 0, 8'h18, 0, 0, 0);
    vecs[10] = v(0, 0, 0, 0, 8'h40, 1, 0, 0, 8'h18, 0, 0, 0);
    vecs[11] = v(0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h18, 0, 0, 0);
    vecs[12] = v(0, 1, 0, 0, 8'h00, 0, 0, 0, 8'h18, 0, 0, 0);
    vecs[13] = v(1, 1, 1, 0, 8'h30, 0, 0, 0, 8'h30, 0, 0, 0);
    vecs[14] = v(1, 0, 1, 0, 8'h50, 1, 0, 0, 8'h50, 1, 0, 0);
    vecs[15] = v(0, 0, 0, 0, 8'h00, 0, 0, 1, 8'h50, 1, 0, 0);
    vecs[16] = v(1, 1, 0, 0, 8'h00, 0, 0, 0, 8'h54, 1, 0, 0);
    vecs[17] = v(1, 0, 0, 0, 8'h00, 0, 1, 0, 8'h34, 0, 0, 0);
    do_reset();
    chk_state("reset", 8'h00, 0, 0, 0);
    // async reset mid-operation with a live stack entry
    drive(1, 0, 0, 0, 8'h08, 1, 0, 0); step();
    drive(1, 1, 0, 0, 8'h00, 0, 0, 0); step(); step();
    chk_state("pre_async", 8'h10, 1, 0, 0);
    drive(0, 0, 0, 0, 8'h00, 0, 0, 0);
    #2 rst = 1'b1;
    #1 chk_state("async_rst", 8'h00, 0, 0, 0);
    step();
    rst = 1'b0;
    drive(1, 1, 0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 63; i++) step();
    chk("wrap.fc", 32'(bus.add), 32'h0FC);
    step();
    chk("wrap.00", 32'(bus.add), 32'h000);
    do_reset();
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].en, vecs[i].inc, vecs[i].jmp, vecs[i].rel, vecs[i].ja, vecs[i].call,
            vecs[i].ret, vecs[i].clr);
      step();
      chk_state($sformatf("vec%0d", i), vecs[i].ea, vecs[i].es, vecs[i].eo, vecs[i].eu);
    end
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drive(1, 0, 0, 0, 8'(i * 16), 1, 0, 0);
      step();
    end
    chk_state("call5", 8'h50, 4, 1, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 8'h00, 0, 1, 0);
      step();
      chk_state($sformatf("pop%0d", i), 8'(8'h34 - i * 16), 3'(3 - i), 1, 0);
    end
    step();
    chk_state("ret_empty", 8'h04, 0, 1, 1);
    drive(1, 0, 0, 0, 8'h00, 0, 0, 1); step();
    chk_state("err_clr", 8'h04, 0, 0, 0);
    drive(1, 0, 0, 0, 8'h00, 0, 1, 1); step();
    chk_state("set_wins", 8'h04, 0, 0, 1);
    drive(0, 0, 0, 0, 8'h00, 0, 1, 1); step();
    chk_state("stall_clr", 8'h04, 0, 0, 0);
    drive(0, 0, 0, 0, 8'h00, 0, 1, 0); step();
    chk_state("stall_noset", 8'h04, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
